// File: rtl/mbist_march_ctrl.sv
// March C- BIST sequencer for a single-port array with pre-registered write data
// and two-edge read latency; records the first miscompare and a saturating error count.
module mbist_march_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int ADDR_MAX   = 15,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [CNT_WIDTH-1:0]  err_count
);

  // Handshake: start is a level request accepted only when busy=0 (IDLE or DONE);
  // while busy=1 it is ignored, and done holds until the next accepted start.
  typedef enum logic [2:0] {
    IDLE, W_SETUP, W_EXEC, R_ISSUE, R_WAIT, R_CMP, DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ADDR_MAX);
  localparam logic [2:0]            LAST_ELEM = 3'd5;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] addr, addr_nx;
  logic [2:0]            elem, elem_nx, elem_inc;
  logic                  down, at_bound, advance, run_start, mismatch;
  logic [DATA_WIDTH-1:0] write_pat, read_pat, diff;

  assign down      = (elem == 3'd3) || (elem == 3'd4);
  assign at_bound  = down ? (addr == '0) : (addr == LAST_ADDR);
  assign elem_inc  = elem + 3'd1;
  // Odd elements write ones; E2/E4 expect ones, every other read expects zeros.
  assign write_pat = {DATA_WIDTH{elem[0]}};
  assign read_pat  = {DATA_WIDTH{(elem == 3'd2) || (elem == 3'd4)}};
  assign diff      = mem_rdata ^ read_pat;
  assign mismatch  = (state == R_CMP) && (diff != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr  <= '0;
      elem  <= '0;
    end else begin
      state <= state_nx;
      addr  <= addr_nx;
      elem  <= elem_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    addr_nx   = addr;
    elem_nx   = elem;
    advance   = 1'b0;
    run_start = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx  = W_SETUP;
          addr_nx   = '0;
          elem_nx   = '0;
          run_start = 1'b1;
        end
      end
      W_SETUP: state_nx = W_EXEC;
      W_EXEC:  advance  = 1'b1;
      R_ISSUE: state_nx = R_WAIT;
      R_WAIT:  state_nx = R_CMP;
      R_CMP: begin
        if (elem == LAST_ELEM) advance = 1'b1;
        else                   state_nx = W_SETUP;
      end
      default: state_nx = IDLE;
    endcase

    // Last op at this address done: step the address, or move to the next element.
    if (advance) begin
      if (!at_bound) begin
        addr_nx  = down ? addr - 1'b1 : addr + 1'b1;
        state_nx = (elem == 3'd0) ? W_SETUP : R_ISSUE;
      end else if (elem == LAST_ELEM) begin
        state_nx = DONE;
        addr_nx  = '0;
        elem_nx  = '0;
      end else begin
        elem_nx  = elem_inc;
        addr_nx  = ((elem_inc == 3'd3) || (elem_inc == 3'd4)) ? LAST_ADDR : '0;
        state_nx = R_ISSUE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_data <= '0;
      err_count <= '0;
    end else if (run_start) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_data <= '0;
      err_count <= '0;
    end else if (mismatch) begin
      if (err_count != '1) err_count <= err_count + 1'b1;
      if (!fail) begin
        fail      <= 1'b1;
        fail_addr <= addr;
        fail_elem <= elem;
        fail_data <= diff;
      end
    end
  end

  // The array write data must already be valid in W_SETUP, one cycle ahead of the write.
  assign mem_write_read = (state == W_EXEC);
  assign mem_addr       = addr;
  assign mem_wdata      = ((state == W_SETUP) || (state == W_EXEC)) ? write_pat : '0;
  assign busy           = (state != IDLE) && (state != DONE);
  assign done           = (state == DONE);

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: behavioural faulty array, table of fault scenarios,
// per-cycle bus trace scoreboard and hand-written reset/start-glitch sequences.
module tb_mbist_march_ctrl;

  localparam int DW  = 8;
  localparam int AW  = 3;
  localparam int N   = 8;
  localparam int CW  = 8;
  localparam int SCW = 4;
  localparam int TW  = 2 + AW + DW;

  logic          clk, rst_n, start;
  logic          mem_write_read;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [DW-1:0] fail_data;
  logic [CW-1:0] err_count;

  logic          s_mem_write_read, s_busy, s_done, s_fail;
  logic [AW-1:0] s_mem_addr, s_fail_addr;
  logic [DW-1:0] s_mem_wdata, s_fail_data;
  logic [2:0]    s_fail_elem;
  logic [SCW-1:0] s_err_count;

  int checks = 0;
  int failures = 0;

  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ADDR_MAX(N-1), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_write_read(mem_write_read), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_data(fail_data),
    .err_count(err_count)
  );

  // Narrow-counter copy fed the same read data, to see err_count saturate.
  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ADDR_MAX(N-1), .CNT_WIDTH(SCW)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_write_read(s_mem_write_read), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_rdata(mem_rdata), .busy(s_busy), .done(s_done), .fail(s_fail),
    .fail_addr(s_fail_addr), .fail_elem(s_fail_elem), .fail_data(s_fail_data),
    .err_count(s_err_count)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- array model ----------------
  logic [DW-1:0] mem [N];
  logic [DW-1:0] wd_q;
  logic [AW-1:0] ra_q;
  logic          flt_all;
  logic [AW-1:0] flt_addr;
  logic [DW-1:0] flt_sa1, flt_sa0;

  function automatic logic [DW-1:0] faulty(input logic [DW-1:0] v, input logic [AW-1:0] a);
    if (flt_all || (a == flt_addr)) return (v | flt_sa1) & ~flt_sa0;
    return v;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem[i] <= DW'($urandom_range(0, 255));
    end else if (mem_write_read) begin
      mem[mem_addr] <= wd_q;
    end
    wd_q      <= mem_wdata;
    ra_q      <= mem_addr;
    mem_rdata <= faulty(mem[ra_q], ra_q);
  end

  // ---------------- scoreboard ----------------
  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] trace_e;
  bit            trace_on;
  int            trace_err;
  string         trace_msg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected bus per busy cycle: {check_wdata, write_read, addr, wdata}.
  task automatic build_trace();
    exp_q.delete();
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        logic [AW-1:0] a;
        logic [DW-1:0] wp;
        a  = (e == 3 || e == 4) ? AW'(N - 1 - i) : AW'(i);
        wp = (e == 1 || e == 3) ? 8'hFF : 8'h00;
        if (e != 0) repeat (3) exp_q.push_back({1'b0, 1'b0, a, 8'h00});
        if (e != 5) begin
          exp_q.push_back({1'b1, 1'b0, a, wp});
          exp_q.push_back({1'b1, 1'b1, a, wp});
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (trace_on && busy === 1'b1) begin
      if (exp_q.size() == 0) begin
        trace_err++;
        if (trace_err == 1) trace_msg = "busy beyond expected trace";
      end else begin
        trace_e = exp_q.pop_front();
        if (mem_write_read !== trace_e[TW-2] || mem_addr !== trace_e[DW +: AW] ||
            (trace_e[TW-1] && mem_wdata !== trace_e[DW-1:0])) begin
          trace_err++;
          if (trace_err == 1)
            trace_msg = $sformatf("wr=%0b addr=%0d wdata=%h vs wr=%0b addr=%0d wdata=%h",
                                  mem_write_read, mem_addr, mem_wdata,
                                  trace_e[TW-2], trace_e[DW +: AW], trace_e[DW-1:0]);
        end
      end
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic          all;
    logic [AW-1:0] faddr;
    logic [DW-1:0] sa1;
    logic [DW-1:0] sa0;
    int            glitch_at;
    logic          e_fail;
    logic [AW-1:0] e_addr;
    logic [2:0]    e_elem;
    logic [DW-1:0] e_data;
    int            e_cnt;
  } vec_t;

  vec_t vecs[8];
  vec_t clean;

  function automatic vec_t mk(input logic all, input logic [AW-1:0] fa, input logic [DW-1:0] s1,
                              input logic [DW-1:0] s0, input int g, input logic ef,
                              input logic [AW-1:0] ea, input logic [2:0] ee,
                              input logic [DW-1:0] ed, input int ec);
    vec_t v;
    v.all = all; v.faddr = fa; v.sa1 = s1; v.sa0 = s0; v.glitch_at = g;
    v.e_fail = ef; v.e_addr = ea; v.e_elem = ee; v.e_data = ed; v.e_cnt = ec;
    return v;
  endfunction

  task automatic set_fault(input vec_t v);
    flt_all  = v.all;
    flt_addr = v.faddr;
    flt_sa1  = v.sa1;
    flt_sa0  = v.sa0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cycles;
    int exp_sat;
    set_fault(v);
    build_trace();
    trace_err = 0;
    trace_msg = "";
    trace_on  = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check({tag, ".clear_on_start"},
          32'({done, fail, fail_addr, fail_elem, fail_data, err_count}), 32'd0);
    cycles = 0;
    while (busy === 1'b1 && cycles < 400) begin
      cycles++;
      start = (cycles == v.glitch_at);
      @(negedge clk);
    end
    start    = 1'b0;
    trace_on = 1'b0;
    exp_sat  = (v.e_cnt > 15) ? 15 : v.e_cnt;
    check({tag, ".busy_cycles"}, 32'(cycles), 32'd200);
    check({tag, ".done"},        32'(done), 32'd1);
    check({tag, ".fail"},        32'(fail), 32'(v.e_fail));
    check({tag, ".fail_addr"},   32'(fail_addr), 32'(v.e_addr));
    check({tag, ".fail_elem"},   32'(fail_elem), 32'(v.e_elem));
    check({tag, ".fail_data"},   32'(fail_data), 32'(v.e_data));
    check({tag, ".err_count"},   32'(err_count), 32'(v.e_cnt));
    check({tag, ".err_count_sat"}, 32'(s_err_count), 32'(exp_sat));
    check($sformatf("%s.trace %s", tag, trace_msg), 32'(trace_err), 32'd0);
    check({tag, ".trace_left"},  32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; trace_on = 1'b0;
    flt_all = 1'b0; flt_addr = '0; flt_sa1 = '0; flt_sa0 = '0;

    //            all  addr  sa1    sa0    glt  fail addr elem data   cnt
    vecs[0] = mk(1'b0, 3'd3, 8'h20, 8'h00, 0,  1'b1, 3'd3, 3'd1, 8'h20, 3);
    vecs[1] = mk(1'b0, 3'd0, 8'h00, 8'h00, 0,  1'b0, 3'd0, 3'd0, 8'h00, 0);
    vecs[2] = mk(1'b0, 3'd0, 8'h00, 8'h01, 0,  1'b1, 3'd0, 3'd2, 8'h01, 2);
    vecs[3] = mk(1'b0, 3'd7, 8'h80, 8'h00, 0,  1'b1, 3'd7, 3'd1, 8'h80, 3);
    vecs[4] = mk(1'b0, 3'd5, 8'h00, 8'h0F, 0,  1'b1, 3'd5, 3'd2, 8'h0F, 2);
    vecs[5] = mk(1'b0, 3'd2, 8'h01, 8'h02, 0,  1'b1, 3'd2, 3'd1, 8'h01, 5);
    vecs[6] = mk(1'b1, 3'd0, 8'h01, 8'h02, 0,  1'b1, 3'd0, 3'd1, 8'h01, 40);
    vecs[7] = mk(1'b0, 3'd3, 8'h20, 8'h00, 50, 1'b1, 3'd3, 3'd1, 8'h20, 3);
    clean = vecs[1];

    repeat (3) @(negedge clk);
    check("reset.bus",  32'({mem_write_read, mem_addr, mem_wdata}), 32'd0);
    check("reset.status", 32'({busy, done, fail, fail_addr, fail_elem}), 32'd0);
    check("reset.data", 32'({fail_data, err_count, s_err_count}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("idle.after_reset", 32'({busy, done}), 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    repeat (5) @(negedge clk);
    check("done.held", 32'({busy, done}), 32'b01);

    // Reset in the middle of a faulty run.
    set_fault(vecs[0]);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (89) @(negedge clk);
    check("mid_reset.pre", 32'({busy, fail}), 32'b11);
    rst_n = 1'b0;
    #1;
    check("mid_reset.bus", 32'({mem_write_read, mem_addr, mem_wdata}), 32'd0);
    check("mid_reset.status", 32'({busy, done, fail, fail_addr, fail_elem}), 32'd0);
    check("mid_reset.data", 32'({fail_data, err_count}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("mid_reset.idle", 32'({busy, done, fail}), 32'd0);
    run_vec(clean, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
